// File: rtl/elevator_dispatcher.sv
// elevator_dispatcher: SCAN scheduler for a single car. It latches call
// buttons, picks the next one-hot floor target for the car controller and
// holds the door open for a programmable dwell at every stop.
module elevator_dispatcher #(
  parameter int          NFLOORS     = 4,
  parameter logic [24:0] TICK_DIV    = 25'd16777216,
  parameter logic [7:0]  DWELL_TICKS = 8'd3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NFLOORS-1:0] call,
  input  logic [NFLOORS-1:0] cur_floor,
  output logic [NFLOORS-1:0] floor_cmd,
  output logic [NFLOORS-1:0] pending,
  output logic               door_open,
  output logic               moving,
  output logic               dir_up,
  output logic               fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic [NFLOORS-1:0] ONE = {{(NFLOORS-1){1'b0}}, 1'b1};

  state_t             state, state_next;
  logic [NFLOORS-1:0] floor_cmd_next, pending_next;
  logic               dir_up_next, fault_next;
  logic [24:0]        prescale, prescale_next;
  logic [7:0]         dwell, dwell_next;
  logic               rearm, rearm_next;

  logic [NFLOORS-1:0] below_mask, at_or_below_mask;
  logic [NFLOORS-1:0] above, below;
  logic [NFLOORS-1:0] cmd_below_mask, cmd_at_or_below_mask;
  logic [NFLOORS-1:0] ahead_up, ahead_down;
  logic               cur_valid, tick_done, dwell_done, same_floor_call;

  // Isolates the lowest set bit (two's complement trick).
  function automatic logic [NFLOORS-1:0] lowest_bit(input logic [NFLOORS-1:0] x);
    return x & (~x + ONE);
  endfunction

  // Isolates the highest set bit.
  function automatic logic [NFLOORS-1:0] highest_bit(input logic [NFLOORS-1:0] x);
    logic [NFLOORS-1:0] res;
    res = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (x[i]) begin
        res    = '0;
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

  // Floor masks relative to the car position and the current target; the
  // one-hot cur_floor minus one gives every floor strictly below it.
  always_comb begin
    below_mask           = cur_floor - ONE;
    at_or_below_mask     = cur_floor | below_mask;
    above                = pending & ~at_or_below_mask;
    below                = pending & below_mask;
    cmd_below_mask       = floor_cmd - ONE;
    cmd_at_or_below_mask = floor_cmd | cmd_below_mask;
    ahead_up             = above & cmd_below_mask;
    ahead_down           = below & ~cmd_at_or_below_mask;
    cur_valid            = (cur_floor != '0) && ((cur_floor & below_mask) == '0);
    tick_done            = (prescale == TICK_DIV - 25'd1);
    dwell_done           = tick_done && (dwell == DWELL_TICKS - 8'd1);
    same_floor_call      = ((call & cur_floor) != '0);
  end

  // Next-state, target selection, call latching and dwell timing.
  always_comb begin
    state_next     = state;
    floor_cmd_next = floor_cmd;
    pending_next   = pending;
    dir_up_next    = dir_up;
    fault_next     = fault;
    prescale_next  = prescale;
    dwell_next     = dwell;
    rearm_next     = 1'b0;

    if (fault) begin
      rearm_next = rearm;
    end else if (!cur_valid) begin
      fault_next = 1'b1;
      rearm_next = rearm;
    end else begin
      pending_next = pending | call;
      case (state)
        IDLE: begin
          floor_cmd_next = cur_floor;
          if ((pending & cur_floor) != '0) begin
            state_next    = DOOR;
            pending_next  = pending_next & ~cur_floor;
            prescale_next = '0;
            dwell_next    = '0;
          end else if (dir_up && (above != '0)) begin
            floor_cmd_next = lowest_bit(above);
            state_next     = MOVE;
          end else if (below != '0) begin
            dir_up_next    = 1'b0;
            floor_cmd_next = highest_bit(below);
            state_next     = MOVE;
          end else if (above != '0) begin
            dir_up_next    = 1'b1;
            floor_cmd_next = lowest_bit(above);
            state_next     = MOVE;
          end
        end
        MOVE: begin
          if (cur_floor == floor_cmd) begin
            state_next    = DOOR;
            pending_next  = pending_next & ~cur_floor;
            prescale_next = '0;
            dwell_next    = '0;
          end else if (dir_up && (ahead_up != '0)) begin
            floor_cmd_next = lowest_bit(ahead_up);
          end else if (!dir_up && (ahead_down != '0)) begin
            floor_cmd_next = highest_bit(ahead_down);
          end
        end
        DOOR: begin
          floor_cmd_next = cur_floor;
          pending_next   = pending_next & ~cur_floor;
          // A same-floor press freezes the dwell; the following edge then
          // restarts it from zero, so the full dwell counts from there.
          if (same_floor_call) begin
            rearm_next = 1'b1;
          end else if (rearm) begin
            prescale_next = '0;
            dwell_next    = '0;
          end else if (dwell_done) begin
            state_next    = IDLE;
            prescale_next = '0;
            dwell_next    = '0;
          end else if (tick_done) begin
            prescale_next = '0;
            dwell_next    = dwell + 8'd1;
          end else begin
            prescale_next = prescale + 25'd1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      floor_cmd <= ONE;
      pending   <= '0;
      dir_up    <= 1'b1;
      fault     <= 1'b0;
      prescale  <= '0;
      dwell     <= '0;
      rearm     <= 1'b0;
    end else begin
      state     <= state_next;
      floor_cmd <= floor_cmd_next;
      pending   <= pending_next;
      dir_up    <= dir_up_next;
      fault     <= fault_next;
      prescale  <= prescale_next;
      dwell     <= dwell_next;
      rearm     <= rearm_next;
    end
  end

  assign door_open = (state == DOOR);
  assign moving    = (state == MOVE);

endmodule
